// File: rtl/stride_counter_pkg.sv
// Shared helpers for the stride up/down counter: lattice maximum and
// D-to-lattice rounding. Used by the RTL and by the testbench.
package stride_counter_pkg;

  // Largest value of the form base + k*step that fits in n bits.
  function automatic int unsigned calc_maxv(int unsigned n, int unsigned step,
                                            int unsigned base);
    int unsigned top;
    top = (32'd1 << n) - 32'd1;
    return base + step * ((top - base) / step);
  endfunction

  // Largest lattice value <= d, or base when d is below the lattice.
  function automatic int unsigned lattice_align(int unsigned d, int unsigned step,
                                                int unsigned base);
    if (d < base) begin
      return base;
    end
    return base + step * ((d - base) / step);
  endfunction

endpackage

// File: rtl/stride_lattice_align.sv
// Combinational rounding of parallel-load data down onto the counter lattice.
// Only instantiated when STRIDE_CNT_LOAD_EN is defined.
module stride_lattice_align
  import stride_counter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned STEP = 2,
  parameter int unsigned BASE = 1
) (
  input  logic [N-1:0] d_i,
  output logic [N-1:0] aligned_o
);

  typedef logic [N-1:0] cnt_t;

  // D is at most 2^N-1, so the aligned value never exceeds MAXV.
  always_comb begin
    aligned_o = cnt_t'(lattice_align(32'(d_i), STEP, BASE));
  end

endmodule

// File: rtl/stride_up_down_counter.sv
// Up/down counter that moves in strides of STEP over the lattice
// {BASE + k*STEP}, wrapping (WRAP=1) or saturating (WRAP=0) at the bounds.
// Optional parallel load is enabled by defining STRIDE_CNT_LOAD_EN.
module stride_up_down_counter
  import stride_counter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned STEP = 2,
  parameter int unsigned BASE = 1,
  parameter int unsigned WRAP = 1
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         enable_i,
  input  logic         up_i,
`ifdef STRIDE_CNT_LOAD_EN
  input  logic         load_i,
  input  logic [N-1:0] d_i,
`endif
  output logic [N-1:0] q_o,
  output logic         at_min_o,
  output logic         at_max_o,
  output logic         bound_o
);

  typedef logic [N-1:0] cnt_t;
  typedef logic [N:0]   ext_t;

  localparam cnt_t BaseV   = cnt_t'(BASE);
  localparam cnt_t MaxV    = cnt_t'(calc_maxv(N, STEP, BASE));
  localparam ext_t StepExt = ext_t'(STEP);
  localparam ext_t MaxExt  = ext_t'(calc_maxv(N, STEP, BASE));

  cnt_t q_q, q_d;
  logic bound_q, bound_d;
  ext_t sum_ext, diff_ext;
  logic up_hit, down_hit;

`ifdef STRIDE_CNT_LOAD_EN
  cnt_t aligned;

  stride_lattice_align #(
    .N    (N),
    .STEP (STEP),
    .BASE (BASE)
  ) u_align (
    .d_i       (d_i),
    .aligned_o (aligned)
  );
`endif

  // Widened stride arithmetic; bound hits are detected from the extra bit.
  always_comb begin
    sum_ext  = {1'b0, q_q} + StepExt;
    diff_ext = {1'b0, q_q} - StepExt;
    up_hit   = (sum_ext > MaxExt);
    // A borrow (bit N) or a result below BASE means we were already at BASE.
    down_hit = diff_ext[N] | (diff_ext[N-1:0] < BaseV);
  end

  // Next-state: Load > Enable > hold (Reset handled in the register).
  always_comb begin
    q_d     = q_q;
    bound_d = 1'b0;
    if (enable_i) begin
      if (up_i) begin
        if (up_hit) begin
          q_d     = (WRAP != 0) ? BaseV : MaxV;
          bound_d = 1'b1;
        end else begin
          q_d = sum_ext[N-1:0];
        end
      end else begin
        if (down_hit) begin
          q_d     = (WRAP != 0) ? MaxV : BaseV;
          bound_d = 1'b1;
        end else begin
          q_d = diff_ext[N-1:0];
        end
      end
    end
`ifdef STRIDE_CNT_LOAD_EN
    if (load_i) begin
      q_d     = aligned;
      bound_d = 1'b0;
    end
`endif
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_q     <= BaseV;
      bound_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      bound_q <= bound_d;
    end
  end

  // Outputs: registered count and pulse, combinational bound flags.
  always_comb begin
    q_o      = q_q;
    bound_o  = bound_q;
    at_min_o = (q_q == BaseV);
    at_max_o = (q_q == MaxV);
  end

endmodule

// File: tb/tb_stride_up_down_counter.sv
// Bench for stride_up_down_counter (N=4, STEP=2, BASE=1), running WRAP=1 and
// WRAP=0 instances side by side on shared stimulus. Load checks are compiled
// in when STRIDE_CNT_LOAD_EN is defined.
module tb_stride_up_down_counter;
  import stride_counter_pkg::*;

  logic clk = 1'b0;
  logic reset, enable, up;
`ifdef STRIDE_CNT_LOAD_EN
  logic       load;
  logic [3:0] d;
`endif
  logic [3:0] q1, q0;
  logic       amin1, amax1, bnd1, amin0, amax0, bnd0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stride_up_down_counter #(.N(4), .STEP(2), .BASE(1), .WRAP(1)) u_wrap (
    .clk_i    (clk),
    .reset_i  (reset),
    .enable_i (enable),
    .up_i     (up),
`ifdef STRIDE_CNT_LOAD_EN
    .load_i   (load),
    .d_i      (d),
`endif
    .q_o      (q1),
    .at_min_o (amin1),
    .at_max_o (amax1),
    .bound_o  (bnd1)
  );

  stride_up_down_counter #(.N(4), .STEP(2), .BASE(1), .WRAP(0)) u_sat (
    .clk_i    (clk),
    .reset_i  (reset),
    .enable_i (enable),
    .up_i     (up),
`ifdef STRIDE_CNT_LOAD_EN
    .load_i   (load),
    .d_i      (d),
`endif
    .q_o      (q0),
    .at_min_o (amin0),
    .at_max_o (amax0),
    .bound_o  (bnd0)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic [3:0] q1;
    logic       b1;
    logic [3:0] q0;
    logic       b0;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic u, input int eq1,
                     input logic eb1, input int eq0, input logic eb0);
    vec_t v;
    v.rst = rst; v.en = en; v.up = u;
    v.q1 = 4'(eq1); v.b1 = eb1; v.q0 = 4'(eq0); v.b0 = eb0;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare both instances against expected count/pulse; flags follow from
  // the expected count on the 1..15 lattice.
  task automatic chk_both(input string tag, input int eq1, input int eb1, input int eq0,
                          input int eb0);
    chk({tag, " q wrap"}, int'(q1), eq1);
    chk({tag, " bound wrap"}, int'(bnd1), eb1);
    chk({tag, " atmin wrap"}, int'(amin1), int'(eq1 == 1));
    chk({tag, " atmax wrap"}, int'(amax1), int'(eq1 == 15));
    chk({tag, " q sat"}, int'(q0), eq0);
    chk({tag, " bound sat"}, int'(bnd0), eb0);
    chk({tag, " atmin sat"}, int'(amin0), int'(eq0 == 1));
    chk({tag, " atmax sat"}, int'(amax0), int'(eq0 == 15));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b1;
`ifdef STRIDE_CNT_LOAD_EN
    load = 1'b0; d = 4'd0;
`endif

    // Reset for two edges, with enable high to show reset dominates.
    add(1, 1, 1, 1, 0, 1, 0);
    add(1, 1, 1, 1, 0, 1, 0);
    // Seven up strides to the top of the lattice.
    add(0, 1, 1, 3, 0, 3, 0);
    add(0, 1, 1, 5, 0, 5, 0);
    add(0, 1, 1, 7, 0, 7, 0);
    add(0, 1, 1, 9, 0, 9, 0);
    add(0, 1, 1, 11, 0, 11, 0);
    add(0, 1, 1, 13, 0, 13, 0);
    add(0, 1, 1, 15, 0, 15, 0);
    // Eighth edge: wrap to 1 or saturate at 15, bound pulses.
    add(0, 1, 1, 1, 1, 15, 1);
    // Idle: hold, pulse drops after one cycle.
    add(0, 0, 1, 1, 0, 15, 0);
    // Back to BASE, then one down stride at the lower bound.
    add(1, 0, 0, 1, 0, 1, 0);
    add(0, 1, 0, 15, 1, 1, 1);
    add(0, 0, 0, 15, 0, 1, 0);
    // Enable 1,0,1 with alternating direction: 1 -> 3, 3, 1.
    add(1, 0, 0, 1, 0, 1, 0);
    add(0, 1, 1, 3, 0, 3, 0);
    add(0, 0, 0, 3, 0, 3, 0);
    add(0, 1, 0, 1, 0, 1, 0);
    // Count to 9, then reset while enabled discards the step.
    add(0, 1, 1, 3, 0, 3, 0);
    add(0, 1, 1, 5, 0, 5, 0);
    add(0, 1, 1, 7, 0, 7, 0);
    add(0, 1, 1, 9, 0, 9, 0);
    add(1, 1, 1, 1, 0, 1, 0);
    add(0, 1, 1, 3, 0, 3, 0);
    // Down from mid-lattice takes effect immediately after an up step.
    add(0, 1, 0, 1, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      enable = vecs[i].en;
      up     = vecs[i].up;
      tick();
      chk_both($sformatf("vec%0d", i), int'(vecs[i].q1), int'(vecs[i].b1),
               int'(vecs[i].q0), int'(vecs[i].b0));
    end

    // Package helpers against hand-computed lattice values.
    chk("pkg maxv", int'(calc_maxv(4, 2, 1)), 15);
    chk("pkg align 8", int'(lattice_align(8, 2, 1)), 7);
    chk("pkg align 0", int'(lattice_align(0, 2, 1)), 1);

`ifdef STRIDE_CNT_LOAD_EN
    // Parallel load rounds down onto the lattice; load beats enable.
    reset = 1'b0; enable = 1'b0; up = 1'b1;
    load = 1'b1; d = 4'd8;  tick(); chk_both("load8", 7, 0, 7, 0);
    d = 4'd0;               tick(); chk_both("load0", 1, 0, 1, 0);
    d = 4'd15;              tick(); chk_both("load15", 15, 0, 15, 0);
    d = 4'd14;              tick(); chk_both("load14", 13, 0, 13, 0);
    enable = 1'b1; d = 4'd8; tick(); chk_both("load+en", 7, 0, 7, 0);
    // Load at MAXV with enable up would otherwise hit the bound.
    d = 4'd15; tick(); chk_both("load15 en", 15, 0, 15, 0);
    load = 1'b0;            tick(); chk_both("after load", 1, 1, 15, 1);
    // Reset beats load.
    reset = 1'b1; load = 1'b1; d = 4'd12; tick(); chk_both("rst>load", 1, 0, 1, 0);
    reset = 1'b0; load = 1'b0; enable = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
